// File: rtl/eth_rx_deframer.sv
// eth_rx_deframer
// Receive-side deframer for the 2-flit Ethernet header carried on a 64-bit
// AXI-stream. Parses dst/src MAC, ethertype and dst id, filters on dst MAC,
// and forwards payload flits through a single output register stage.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   stream_in_*            64-bit input stream (byte 0 at [63:56])
//   stream_out_*           payload stream, registered
//   hdr_valid              one-cycle pulse after an accepted header
//   hdr_mac_dst/src,
//   hdr_ethertype,
//   hdr_dst_id             metadata of the last accepted header
//   cnt_rx_ok/drop/err     forwarded / filtered / malformed frame counters
module eth_rx_deframer #(
    parameter logic [47:0] MAC_ADDR_FPGA = 48'hfa163e55ca02,
    parameter logic        PROMISC       = 1'b0,
    parameter int          CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      stream_in_DATA,
    input  logic [7:0]       stream_in_KEEP,
    input  logic             stream_in_LAST,
    input  logic             stream_in_VALID,
    output logic             stream_in_READY,
    output logic [63:0]      stream_out_DATA,
    output logic [7:0]       stream_out_KEEP,
    output logic             stream_out_LAST,
    output logic             stream_out_VALID,
    input  logic             stream_out_READY,
    output logic             hdr_valid,
    output logic [47:0]      hdr_mac_dst,
    output logic [47:0]      hdr_mac_src,
    output logic [15:0]      hdr_ethertype,
    output logic [7:0]       hdr_dst_id,
    output logic [CNT_W-1:0] cnt_rx_ok,
    output logic [CNT_W-1:0] cnt_drop,
    output logic [CNT_W-1:0] cnt_err
);

    typedef enum logic [1:0] {
        HDR0    = 2'd0,
        HDR1    = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic             ready_en_r;
    logic [47:0]      dst_sh_r;
    logic [15:0]      src_hi_sh_r;
    logic [63:0]      out_data_r;
    logic [7:0]       out_keep_r;
    logic             out_last_r;
    logic             out_valid_r;
    logic             hdr_valid_r;
    logic [47:0]      hdr_mac_dst_r;
    logic [47:0]      hdr_mac_src_r;
    logic [15:0]      hdr_ethertype_r;
    logic [7:0]       hdr_dst_id_r;
    logic [CNT_W-1:0] cnt_rx_ok_r;
    logic [CNT_W-1:0] cnt_drop_r;
    logic [CNT_W-1:0] cnt_err_r;

    logic in_ready_s;
    logic in_xfer_s;
    logic out_xfer_s;
    logic keep_full_s;
    logic dst_ok_s;

    // Handshake decode and dst MAC filter. READY is held low until the first
    // edge after reset; in PAYLOAD it follows the output register so a
    // draining register can take a new flit in the same cycle.
    always_comb begin
        in_ready_s  = 1'b0;
        keep_full_s = (stream_in_KEEP == 8'hff);
        dst_ok_s    = PROMISC || (dst_sh_r == MAC_ADDR_FPGA) ||
                      (dst_sh_r == 48'hffffffffffff);
        if (!ready_en_r) begin
            in_ready_s = 1'b0;
        end else if (state_r == PAYLOAD) begin
            in_ready_s = !out_valid_r || stream_out_READY;
        end else begin
            in_ready_s = 1'b1;
        end
        in_xfer_s  = stream_in_VALID && in_ready_s;
        out_xfer_s = out_valid_r && stream_out_READY;
    end

    // Header FSM, metadata latch, counters and payload output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= HDR0;
            ready_en_r      <= 1'b0;
            dst_sh_r        <= 48'd0;
            src_hi_sh_r     <= 16'd0;
            out_data_r      <= 64'd0;
            out_keep_r      <= 8'd0;
            out_last_r      <= 1'b0;
            out_valid_r     <= 1'b0;
            hdr_valid_r     <= 1'b0;
            hdr_mac_dst_r   <= 48'd0;
            hdr_mac_src_r   <= 48'd0;
            hdr_ethertype_r <= 16'd0;
            hdr_dst_id_r    <= 8'd0;
            cnt_rx_ok_r     <= {CNT_W{1'b0}};
            cnt_drop_r      <= {CNT_W{1'b0}};
            cnt_err_r       <= {CNT_W{1'b0}};
        end else begin
            ready_en_r  <= 1'b1;
            hdr_valid_r <= 1'b0;
            if (in_xfer_s) begin
                case (state_r)
                    HDR0: begin
                        if (stream_in_LAST || !keep_full_s) begin
                            cnt_err_r <= cnt_err_r + CNT_ONE;
                        end else begin
                            dst_sh_r    <= stream_in_DATA[63:16];
                            src_hi_sh_r <= stream_in_DATA[15:0];
                            state_r     <= HDR1;
                        end
                    end
                    HDR1: begin
                        if (stream_in_LAST || !keep_full_s) begin
                            cnt_err_r <= cnt_err_r + CNT_ONE;
                            state_r   <= HDR0;
                        end else if (dst_ok_s) begin
                            hdr_mac_dst_r   <= dst_sh_r;
                            hdr_mac_src_r   <= {src_hi_sh_r, stream_in_DATA[63:32]};
                            hdr_ethertype_r <= stream_in_DATA[31:16];
                            hdr_dst_id_r    <= stream_in_DATA[15:8];
                            hdr_valid_r     <= 1'b1;
                            state_r         <= PAYLOAD;
                        end else begin
                            state_r <= DROP;
                        end
                    end
                    PAYLOAD: begin
                        if (stream_in_LAST) begin
                            cnt_rx_ok_r <= cnt_rx_ok_r + CNT_ONE;
                            state_r     <= HDR0;
                        end
                    end
                    DROP: begin
                        if (stream_in_LAST) begin
                            cnt_drop_r <= cnt_drop_r + CNT_ONE;
                            state_r    <= HDR0;
                        end
                    end
                    default: state_r <= HDR0;
                endcase
            end
            // A load wins over a drain, so VALID stays high on back-to-back flits.
            if (in_xfer_s && (state_r == PAYLOAD)) begin
                out_data_r  <= stream_in_DATA;
                out_keep_r  <= stream_in_KEEP;
                out_last_r  <= stream_in_LAST;
                out_valid_r <= 1'b1;
            end else if (out_xfer_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign stream_in_READY  = in_ready_s;
    assign stream_out_DATA  = out_data_r;
    assign stream_out_KEEP  = out_keep_r;
    assign stream_out_LAST  = out_last_r;
    assign stream_out_VALID = out_valid_r;
    assign hdr_valid        = hdr_valid_r;
    assign hdr_mac_dst      = hdr_mac_dst_r;
    assign hdr_mac_src      = hdr_mac_src_r;
    assign hdr_ethertype    = hdr_ethertype_r;
    assign hdr_dst_id       = hdr_dst_id_r;
    assign cnt_rx_ok        = cnt_rx_ok_r;
    assign cnt_drop         = cnt_drop_r;
    assign cnt_err          = cnt_err_r;

endmodule

// File: tb/tb_eth_rx_deframer.sv
// Testbench for eth_rx_deframer: directed frames, scoreboard of expected
// payload flits, output backpressure, throughput and mid-frame reset.
module tb_eth_rx_deframer;

    logic        clk;
    logic        rst_n;
    logic [63:0] stream_in_DATA;
    logic [7:0]  stream_in_KEEP;
    logic        stream_in_LAST;
    logic        stream_in_VALID;
    logic        stream_in_READY;
    logic [63:0] stream_out_DATA;
    logic [7:0]  stream_out_KEEP;
    logic        stream_out_LAST;
    logic        stream_out_VALID;
    logic        stream_out_READY;
    logic        hdr_valid;
    logic [47:0] hdr_mac_dst;
    logic [47:0] hdr_mac_src;
    logic [15:0] hdr_ethertype;
    logic [7:0]  hdr_dst_id;
    logic [31:0] cnt_rx_ok;
    logic [31:0] cnt_drop;
    logic [31:0] cnt_err;

    eth_rx_deframer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stream_in_DATA   (stream_in_DATA),
        .stream_in_KEEP   (stream_in_KEEP),
        .stream_in_LAST   (stream_in_LAST),
        .stream_in_VALID  (stream_in_VALID),
        .stream_in_READY  (stream_in_READY),
        .stream_out_DATA  (stream_out_DATA),
        .stream_out_KEEP  (stream_out_KEEP),
        .stream_out_LAST  (stream_out_LAST),
        .stream_out_VALID (stream_out_VALID),
        .stream_out_READY (stream_out_READY),
        .hdr_valid        (hdr_valid),
        .hdr_mac_dst      (hdr_mac_dst),
        .hdr_mac_src      (hdr_mac_src),
        .hdr_ethertype    (hdr_ethertype),
        .hdr_dst_id       (hdr_dst_id),
        .cnt_rx_ok        (cnt_rx_ok),
        .cnt_drop         (cnt_drop),
        .cnt_err          (cnt_err)
    );

    int checks = 0;
    int failures = 0;
    int hdr_pulses = 0;
    int out_xfers = 0;
    int stall_cycles = 0;
    int exp_ok = 0;
    int exp_drop = 0;
    int exp_err = 0;
    logic [72:0] exp_q[$];
    logic        bp_en = 1'b0;
    int          bp_idx = 0;
    logic [3:0]  bp_pat = 4'b1001;
    logic        stall_prev = 1'b0;
    logic [72:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sink READY: constant 1 or the 1,0,0,1 backpressure pattern.
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            stream_out_READY = bp_pat[3 - bp_idx];
            bp_idx = (bp_idx + 1) % 4;
        end else begin
            stream_out_READY = 1'b1;
        end
    end

    // Output monitor: scoreboard compare, stall stability, hdr_valid pulses.
    always @(negedge clk) begin
        logic [72:0] cur;
        logic [72:0] e;
        cur = {stream_out_DATA, stream_out_KEEP, stream_out_LAST};
        if (hdr_valid === 1'b1) hdr_pulses++;
        if (stall_prev && stream_out_VALID === 1'b1) chk("stall_hold", 128'(cur), 128'(held));
        if (stream_out_VALID === 1'b1 && stream_out_READY === 1'b1) begin
            out_xfers++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_out observed=%0h expected=none", cur);
            end else begin
                e = exp_q.pop_front();
                chk("out_flit", 128'(cur), 128'(e));
            end
        end
        stall_prev = (stream_out_VALID === 1'b1) && (stream_out_READY === 1'b0);
        held = cur;
    end

    task automatic send_flit(input logic [63:0] d, input logic [7:0] k, input logic l);
        logic ok;
        logic done;
        done = 1'b0;
        stream_in_DATA  = d;
        stream_in_KEEP  = k;
        stream_in_LAST  = l;
        stream_in_VALID = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ok = stream_in_READY;
            @(posedge clk);
            #1;
            if (ok) begin
                done = 1'b1;
                break;
            end
            stall_cycles++;
        end
        if (!done) chk("in_timeout", 128'(done), 128'(1'b1));
        stream_in_VALID = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] f0, input logic [63:0] f1,
                              input int n, input logic fwd, input logic [7:0] seed);
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        send_flit(f0, 8'hff, 1'b0);
        send_flit(f1, 8'hff, 1'b0);
        for (int i = 0; i < n; i++) begin
            d = {seed, 56'(i)} ^ 64'h0123456789abcdef;
            l = (i == n - 1);
            k = l ? 8'h0f : ((i == 1) ? 8'h00 : 8'hff);
            if (fwd) exp_q.push_back({d, k, l});
            send_flit(d, k, l);
        end
    endtask

    task automatic drain;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && stream_out_VALID === 1'b0) break;
        end
        chk("drain", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts;
        chk("cnt_rx_ok", 128'(cnt_rx_ok), 128'(exp_ok));
        chk("cnt_drop", 128'(cnt_drop), 128'(exp_drop));
        chk("cnt_err", 128'(cnt_err), 128'(exp_err));
    endtask

    initial begin
        int p0;
        int x0;
        stream_in_DATA  = 64'd0;
        stream_in_KEEP  = 8'd0;
        stream_in_LAST  = 1'b0;
        stream_in_VALID = 1'b0;
        stream_out_READY = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(stream_in_READY), 128'd0);
        chk("rst_out_valid", 128'(stream_out_VALID), 128'd0);
        chk("rst_hdr_valid", 128'(hdr_valid), 128'd0);
        chk("rst_hdr_src", 128'(hdr_mac_src), 128'd0);
        chk_cnts();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 128'(stream_in_READY), 128'd1);

        // Reference frame.
        p0 = hdr_pulses;
        send_flit(64'hfa163e55ca020cc4, 8'hff, 1'b0);
        send_flit(64'h7a88c04708000100, 8'hff, 1'b0);
        exp_q.push_back({64'h0100000100030000, 8'hff, 1'b0});
        send_flit(64'h0100000100030000, 8'hff, 1'b0);
        exp_q.push_back({64'h5073930200000000, 8'h0f, 1'b1});
        send_flit(64'h5073930200000000, 8'h0f, 1'b1);
        exp_ok++;
        drain();
        chk("ref_hdr_pulses", 128'(hdr_pulses - p0), 128'd1);
        chk("ref_mac_dst", 128'(hdr_mac_dst), 128'h00fa163e55ca02);
        chk("ref_mac_src", 128'(hdr_mac_src), 128'h0cc47a88c047);
        chk("ref_ethertype", 128'(hdr_ethertype), 128'h0800);
        chk("ref_dst_id", 128'(hdr_dst_id), 128'h01);
        chk_cnts();

        // Foreign dst MAC: dropped, metadata untouched.
        p0 = hdr_pulses;
        x0 = out_xfers;
        send_frame(64'h0a0b0c0d0e0f0cc4, 64'h7a88c04708000100, 3, 1'b0, 8'h11);
        exp_drop++;
        drain();
        chk("drop_hdr_pulses", 128'(hdr_pulses - p0), 128'd0);
        chk("drop_out_xfers", 128'(out_xfers - x0), 128'd0);
        chk("drop_mac_src", 128'(hdr_mac_src), 128'h0cc47a88c047);
        chk("drop_mac_dst", 128'(hdr_mac_dst), 128'h00fa163e55ca02);
        chk_cnts();

        // Broadcast: forwarded, including a KEEP=0 payload flit.
        p0 = hdr_pulses;
        send_frame(64'hffffffffffff1234, 64'h5678abcd86dd0200, 3, 1'b1, 8'h22);
        exp_ok++;
        drain();
        chk("bc_hdr_pulses", 128'(hdr_pulses - p0), 128'd1);
        chk("bc_mac_dst", 128'(hdr_mac_dst), 128'h00ffffffffffff);
        chk("bc_mac_src", 128'(hdr_mac_src), 128'h12345678abcd);
        chk("bc_ethertype", 128'(hdr_ethertype), 128'h86dd);
        chk("bc_dst_id", 128'(hdr_dst_id), 128'h02);
        chk_cnts();

        // Partial KEEP on a header flit, then a runt, then a good frame.
        p0 = hdr_pulses;
        send_flit(64'hfa163e55ca020cc4, 8'h0f, 1'b0);
        exp_err++;
        send_flit(64'hfa163e55ca020cc4, 8'hff, 1'b0);
        send_flit(64'h7a88c04708000100, 8'hff, 1'b1);
        exp_err++;
        drain();
        chk("runt_hdr_pulses", 128'(hdr_pulses - p0), 128'd0);
        chk_cnts();
        send_frame(64'hfa163e55ca020cc4, 64'h7a88c04708000300, 2, 1'b1, 8'h33);
        exp_ok++;
        drain();
        chk("post_runt_dst_id", 128'(hdr_dst_id), 128'h03);
        chk_cnts();

        // Output backpressure on a 6-flit frame.
        bp_en = 1'b1;
        bp_idx = 0;
        x0 = out_xfers;
        send_frame(64'hfa163e55ca020cc4, 64'h7a88c04708000400, 6, 1'b1, 8'h44);
        exp_ok++;
        drain();
        chk("bp_out_xfers", 128'(out_xfers - x0), 128'd6);
        chk_cnts();
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // Full throughput with READY held high.
        stall_cycles = 0;
        send_frame(64'hfa163e55ca020cc4, 64'h7a88c04708000500, 6, 1'b1, 8'h55);
        exp_ok++;
        chk("tput_stalls", 128'(stall_cycles), 128'd0);
        drain();
        chk_cnts();

        // Reset while the 3rd payload flit is offered.
        send_flit(64'hfa163e55ca020cc4, 8'hff, 1'b0);
        send_flit(64'h7a88c04708000600, 8'hff, 1'b0);
        exp_q.push_back({64'haaaa000000000001, 8'hff, 1'b0});
        send_flit(64'haaaa000000000001, 8'hff, 1'b0);
        exp_q.push_back({64'haaaa000000000002, 8'hff, 1'b0});
        send_flit(64'haaaa000000000002, 8'hff, 1'b0);
        stream_in_DATA  = 64'haaaa000000000003;
        stream_in_KEEP  = 8'hff;
        stream_in_LAST  = 1'b0;
        stream_in_VALID = 1'b1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_ok = 0;
        exp_drop = 0;
        exp_err = 0;
        chk("mid_rst_out_valid", 128'(stream_out_VALID), 128'd0);
        chk("mid_rst_out_data", 128'(stream_out_DATA), 128'd0);
        chk("mid_rst_in_ready", 128'(stream_in_READY), 128'd0);
        chk("mid_rst_hdr_dst_id", 128'(hdr_dst_id), 128'd0);
        chk_cnts();
        stream_in_VALID = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        p0 = hdr_pulses;
        send_frame(64'hfa163e55ca020cc4, 64'h7a88c04708000700, 2, 1'b1, 8'h77);
        exp_ok++;
        drain();
        chk("post_rst_hdr_pulses", 128'(hdr_pulses - p0), 128'd1);
        chk("post_rst_dst_id", 128'(hdr_dst_id), 128'h07);
        chk("post_rst_mac_src", 128'(hdr_mac_src), 128'h0cc47a88c047);
        chk_cnts();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_rx_deframer.md
Name: eth_rx_deframer

Overview:
- Receive-side counterpart of the Ethernet stimulus/framer path.
- Consumes 64-bit AXI-stream frames carrying the team's 2-flit Ethernet header, then parses and filters that header.
- Forwards payload flits downstream through a one-flit register stage.
- Exposes header metadata and statistics counters so benches and the FPGA top can check what the far end transmitted.

Parameters:
- MAC_ADDR_FPGA, 48'hfa163e55ca02, local MAC. Frames whose dst MAC matches are accepted.
- PROMISC, 1'b0, 1 = accept any dst MAC.
- CNT_W, 32, width of the statistics counters. Counters wrap modulo 2^CNT_W.

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous active-low reset
- stream_in_DATA  input  64  frame data; byte 0 of the flit is [63:56]
- stream_in_KEEP  input  8  byte enables; bit 7 maps to [63:56]
- stream_in_LAST  input  1  final flit of frame
- stream_in_VALID  input  1  source valid
- stream_in_READY  output  1  block ready
- stream_out_DATA  output  64  payload data
- stream_out_KEEP  output  8  payload byte enables
- stream_out_LAST  output  1  final payload flit
- stream_out_VALID  output  1  payload valid
- stream_out_READY  input  1  sink ready
- hdr_valid  output  1  one-cycle pulse when an accepted header completes
- hdr_mac_dst  output  48  latched dst MAC
- hdr_mac_src  output  48  latched src MAC
- hdr_ethertype  output  16  latched ethertype
- hdr_dst_id  output  8  latched destination id byte
- cnt_rx_ok  output  CNT_W  frames forwarded
- cnt_drop  output  CNT_W  frames filtered on MAC
- cnt_err  output  CNT_W  malformed frames

Behaviour:
- Reset: clk and rst_n only; reset is asynchronous and active-low. While rst_n=0:
  - all outputs are 0, except stream_in_READY, which is 0;
  - state is HDR0.
  - stream_in_READY goes to 1 in the first cycle after rst_n deasserts.
- Reset mid-frame: the partial frame is discarded and no counter is incremented. After reset the block resyncs at the next flit, which it treats as HDR0.
- Header format (16 bytes, KEEP must be 8'hff on both header flits):
  - flit0: [63:16] dst MAC, [15:0] src MAC[47:32];
  - flit1: [63:32] src MAC[31:0], [31:16] ethertype, [15:8] dst id, [7:0] reserved (ignored).
- A transfer occurs on a clock edge where VALID && READY.
- FSM states: HDR0, HDR1, PAYLOAD, DROP.
  - HDR0, on transfer:
    - LAST=1 or KEEP!=ff: cnt_err+1, stay in HDR0.
    - otherwise: capture fields into shadow registers, go to HDR1.
  - HDR1, on transfer:
    - LAST=1 (runt) or KEEP!=ff: cnt_err+1, go to HDR0.
    - dst MAC == MAC_ADDR_FPGA, or dst MAC == 48'hffffffffffff, or PROMISC=1: copy shadow fields to the hdr_* outputs, pulse hdr_valid the next cycle, go to PAYLOAD.
    - otherwise: go to DROP.
  - PAYLOAD, on transfer:
    - load the output register (DATA, KEEP, LAST, VALID=1).
    - LAST=1: cnt_rx_ok+1, go to HDR0.
    - KEEP==0 on any payload flit: forward it unchanged, no error.
  - DROP: consume flits. On the LAST transfer: cnt_drop+1, go to HDR0.
- stream_in_READY:
  - 1 in HDR0, HDR1 and DROP;
  - in PAYLOAD it is !stream_out_VALID || stream_out_READY, so back-to-back payload streams at one flit per clock without loss.
- Output register:
  - stream_out_VALID clears on an output transfer when no new flit loads in the same cycle.
  - Simultaneous output drain and input load: the register takes the new flit and VALID stays 1.
  - DATA/KEEP/LAST are held stable while VALID && !READY.
- Latency: a payload flit accepted at edge N is visible on stream_out after edge N. The header adds 2 accepted flits before the first payload flit.
- hdr_* outputs hold until the next accepted header. They do not change on dropped or erroneous frames.
- A frame's counter increments exactly once, on the edge where its LAST flit is accepted. When the LAST flit loads the output register, cnt_rx_ok increments on that same edge.

Test Plan:
- Reset then frame: flit0=64'hfa163e55ca020cc4, flit1=64'h7a88c04708000100, then payload 64'h0100000100030000 keep ff, then 64'h5073930200000000 keep 0f last.
  - Required: hdr_valid one pulse; hdr_mac_src=0cc47a88c047, ethertype=0800, dst_id=01.
  - Required: two payload flits out, identical DATA/KEEP/LAST; cnt_rx_ok=1.
- Same frame with dst MAC 0a0b0c0d0e0f, PROMISC=0 -> no stream_out_VALID, no hdr_valid, cnt_drop=1, hdr_* unchanged.
- Broadcast dst ffffffffffff -> frame forwarded, cnt_rx_ok increments.
- Runt: a frame of 2 header flits with LAST on flit1 -> cnt_err=1, no hdr_valid. Then a valid next frame is forwarded normally.
- Backpressure on a 6-payload-flit frame:
  - stream_out_READY toggles 1,0,0,1,... -> all 6 flits delivered in order, none duplicated;
  - output held stable while stalled;
  - with READY=1 throughout, throughput is 1 flit/clk.
- Assert rst_n=0 on the 3rd payload flit -> outputs 0 immediately, counters 0. The next frame parses from HDR0 correctly.
